// File: rtl/range_error_avg_pkg.sv
// range_error_avg_pkg
// Shared definitions for the guidance datapath stages (range error,
// magnitude, steering): FSM state encoding and datapath widths.
//   SAMPLE_W : width of unsigned range/angle samples and targets
//   ERR_W    : width of the signed error (one extra bit over SAMPLE_W)
//   state_t  : ACCUM / COMPUTE / HOLD window states
package range_error_avg_pkg;

    localparam int SAMPLE_W = 8;
    localparam int ERR_W    = 9;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        COMPUTE = 2'd1,
        HOLD    = 2'd2
    } state_t;

endpackage

// File: rtl/range_error_avg_if.sv
// range_error_avg_if
// Bundles the sample input, target load and error output handshakes of
// the range error stage.
//   master : producer/consumer side (drives samples, target, err_ready)
//   slave  : range_error_avg side (drives sample_ready, err, err_valid,
//            overrun)
interface range_error_avg_if;
    import range_error_avg_pkg::*;

    logic                       sample_valid;
    logic                       sample_ready;
    logic [SAMPLE_W-1:0]        sample;
    logic                       target_load;
    logic [SAMPLE_W-1:0]        target;
    logic                       err_valid;
    logic                       err_ready;
    logic signed [ERR_W-1:0]    err;
    logic                       overrun;

    modport master (
        output sample_valid, sample, target_load, target, err_ready,
        input  sample_ready, err_valid, err, overrun
    );

    modport slave (
        input  sample_valid, sample, target_load, target, err_ready,
        output sample_ready, err_valid, err, overrun
    );

endinterface

// File: rtl/range_error_avg_window_accumulator.sv
// range_error_avg_window_accumulator
// Sums a window of 2^AVG_LOG2 unsigned samples and flags the sample that
// completes the window.
//   clock, reset_n : clock and asynchronous active-low reset
//   add            : a sample is accepted this cycle
//   clear          : start a fresh window (has priority over add)
//   sample         : unsigned sample value
//   avg            : accumulator >> AVG_LOG2, truncated to SAMPLE_W bits
//   window_done    : the sample accepted this cycle fills the window
module range_error_avg_window_accumulator
    import range_error_avg_pkg::*;
#(
    parameter int AVG_LOG2 = 3
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                add,
    input  logic                clear,
    input  logic [SAMPLE_W-1:0] sample,
    output logic [SAMPLE_W-1:0] avg,
    output logic                window_done
);

    localparam int ACC_W = SAMPLE_W + AVG_LOG2;
    // One extra count bit so the window size itself is representable,
    // which also keeps the width non-zero when AVG_LOG2 = 0.
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int WIN   = 1 << AVG_LOG2;

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc   <= '0;
            count <= '0;
        end else if (clear) begin
            acc   <= '0;
            count <= '0;
        end else if (add) begin
            acc   <= acc + ACC_W'(sample);
            count <= count + CNT_W'(1);
        end
    end

    assign window_done = add && (count == CNT_W'(WIN - 1));

    // A full window of 8-bit samples fits ACC_W exactly, so the top
    // SAMPLE_W bits are the truncated mean.
    assign avg = acc[ACC_W-1 -: SAMPLE_W];

endmodule

// File: rtl/range_error_avg.sv
// range_error_avg
// Averages windows of 2^AVG_LOG2 unsigned samples and emits the signed
// error (average - target) with a valid/ready handshake.
//   clock   : system clock
//   reset_n : asynchronous active-low reset
//   bus     : range_error_avg_if.slave
//             sample_valid/sample_ready/sample : sample input handshake
//             target_load/target               : shadow target load
//             err_valid/err_ready/err          : error output handshake
//             overrun : sticky, a sample was offered while not ready
module range_error_avg
    import range_error_avg_pkg::*;
#(
    parameter int AVG_LOG2 = 3
) (
    input  logic               clock,
    input  logic               reset_n,
    range_error_avg_if.slave   bus
);

    state_t                  state;
    state_t                  state_next;
    logic                    ready;
    logic                    accept;
    logic                    window_done;
    logic                    handshake;
    logic [SAMPLE_W-1:0]     avg;
    logic [SAMPLE_W-1:0]     shadow_target;
    logic [SAMPLE_W-1:0]     working_target;
    logic                    start_pending;
    logic signed [ERR_W-1:0] err_q;
    logic                    err_valid_q;
    logic                    overrun_q;

    // Both operands are zero-extended, so the result spans -255..+255 and
    // never reaches -256.
    function automatic logic signed [ERR_W-1:0] range_err(
        input logic [SAMPLE_W-1:0] mean,
        input logic [SAMPLE_W-1:0] tgt
    );
        return $signed({1'b0, mean}) - $signed({1'b0, tgt});
    endfunction

    assign ready     = (state == ACCUM);
    assign accept    = bus.sample_valid && ready;
    assign handshake = (state == HOLD) && bus.err_ready;

    range_error_avg_window_accumulator #(
        .AVG_LOG2 (AVG_LOG2)
    ) u_window (
        .clock       (clock),
        .reset_n     (reset_n),
        .add         (accept),
        .clear       (handshake),
        .sample      (bus.sample),
        .avg         (avg),
        .window_done (window_done)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ACCUM:   if (window_done) state_next = COMPUTE;
            COMPUTE: state_next = HOLD;
            HOLD:    if (bus.err_ready) state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    // The working target only changes at a window start (first edge out of
    // reset, or the output handshake); a load in that same cycle bypasses
    // the shadow so the new value is used immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shadow_target  <= '0;
            working_target <= '0;
            start_pending  <= 1'b1;
        end else begin
            if (bus.target_load) begin
                shadow_target <= bus.target;
            end
            if (start_pending || handshake) begin
                working_target <= bus.target_load ? bus.target : shadow_target;
            end
            start_pending <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_q       <= '0;
            err_valid_q <= 1'b0;
        end else if (state == COMPUTE) begin
            err_q       <= range_err(avg, working_target);
            err_valid_q <= 1'b1;
        end else if (handshake) begin
            err_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overrun_q <= 1'b0;
        end else if (bus.sample_valid && !ready) begin
            overrun_q <= 1'b1;
        end
    end

    assign bus.sample_ready = ready;
    assign bus.err_valid    = err_valid_q;
    assign bus.err          = err_q;
    assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_range_error_avg.sv
// tb_range_error_avg
// Self-checking bench for range_error_avg (AVG_LOG2 = 3). A window-level
// reference model predicts readiness, overrun and each error result; the
// results go into a scoreboard queue that a negedge monitor drains on each
// output handshake. Directed known-answer sequences are followed by
// randomized traffic.
module tb_range_error_avg;

    localparam int AVG_LOG2 = 3;
    localparam int WIN      = 1 << AVG_LOG2;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    range_error_avg_if bus();

    range_error_avg #(
        .AVG_LOG2 (AVG_LOG2)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int tests  = 0;
    int failed = 0;

    // Reference model state.
    int  win_samples[$];
    int  sb[$];
    bit  m_collect = 1'b1;
    bit  m_due     = 1'b0;
    bit  m_vis     = 1'b0;
    bit  m_over    = 1'b0;
    bit  m_start   = 1'b1;
    int  m_shadow  = 0;
    int  m_working = 0;
    int  m_pend    = 0;
    int  m_last    = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one window is a list of accepted samples; its result appears
    // one cycle after the window fills and stays until the consumer takes it.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            win_samples.delete();
            sb.delete();
            m_collect = 1'b1;
            m_due     = 1'b0;
            m_vis     = 1'b0;
            m_over    = 1'b0;
            m_start   = 1'b1;
            m_shadow  = 0;
            m_working = 0;
            m_last    = 0;
        end else begin
            bit new_window;
            new_window = m_start;
            if (bus.sample_valid && !m_collect) m_over = 1'b1;
            if (m_collect) begin
                if (bus.sample_valid) begin
                    win_samples.push_back(int'(bus.sample));
                    if (win_samples.size() == WIN) begin
                        int sum;
                        sum = 0;
                        foreach (win_samples[i]) sum += win_samples[i];
                        m_pend    = (sum / WIN) - m_working;
                        m_collect = 1'b0;
                        m_due     = 1'b1;
                    end
                end
            end else if (m_due) begin
                m_due = 1'b0;
                m_vis = 1'b1;
                sb.push_back(m_pend);
            end else if (m_vis && bus.err_ready) begin
                m_vis      = 1'b0;
                m_collect  = 1'b1;
                new_window = 1'b1;
                win_samples.delete();
            end
            if (bus.target_load) m_shadow = int'(bus.target);
            if (new_window) m_working = m_shadow;
            m_start = 1'b0;
        end
    end

    // Monitor: compare every output each cycle, pop on handshake.
    always @(negedge clock) begin
        if (reset_n) begin
            check("sample_ready", int'(bus.sample_ready), int'(m_collect));
            check("err_valid", int'(bus.err_valid), int'(m_vis));
            check("overrun", int'(bus.overrun), int'(m_over));
            if (bus.err_valid) begin
                tests++;
                if (sb.size() == 0) begin
                    failed++;
                    $display("FAIL scoreboard: err_valid with no expected result, err=%0d", bus.err);
                end else begin
                    if (bus.err != sb[0]) begin
                        failed++;
                        $display("FAIL err: got %0d, expected %0d at %0t", bus.err, sb[0], $time);
                    end
                    if (bus.err_ready) m_last = sb.pop_front();
                end
            end else begin
                check("err_hold", int'(bus.err), m_last);
            end
        end
    end

    task automatic step(input logic sv, input logic [7:0] s, input logic tl,
                        input logic [7:0] t, input logic er);
        bus.sample_valid = sv;
        bus.sample       = s;
        bus.target_load  = tl;
        bus.target       = t;
        bus.err_ready    = er;
        @(posedge clock);
        #2;
    endtask

    // Idles the inputs and waits (bounded) for a result, then checks it
    // against a known answer and the number of cycles it took.
    task automatic wait_result(input string name, input int exp, input int exp_wait);
        int k;
        k = 0;
        bus.sample_valid = 1'b0;
        bus.target_load  = 1'b0;
        bus.err_ready    = 1'b0;
        while (!bus.err_valid && k < 20) begin
            @(posedge clock);
            #2;
            k++;
        end
        if (!bus.err_valid) begin
            check({name, "_timeout"}, int'(bus.err_valid), 1);
        end else begin
            check(name, int'(bus.err), exp);
            if (exp_wait >= 0) check({name, "_latency"}, k, exp_wait);
        end
    endtask

    task automatic reset_pulse(input string name);
        #1;
        reset_n = 1'b0;
        #1;
        check({name, "_err_valid"}, int'(bus.err_valid), 0);
        check({name, "_err"}, int'(bus.err), 0);
        check({name, "_sample_ready"}, int'(bus.sample_ready), 1);
        check({name, "_overrun"}, int'(bus.overrun), 0);
        bus.sample_valid = 1'b0;
        bus.target_load  = 1'b0;
        bus.err_ready    = 1'b0;
        @(posedge clock);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        bus.sample_valid = 1'b0;
        bus.sample       = '0;
        bus.target_load  = 1'b0;
        bus.target       = '0;
        bus.err_ready    = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        reset_pulse("reset0");

        // Positive error: target 100 loaded at reset exit, eight 120s.
        step(1'b1, 8'd120, 1'b1, 8'd100, 1'b0);
        repeat (WIN - 1) step(1'b1, 8'd120, 1'b0, 8'd0, 1'b0);
        wait_result("positive", 20, 1);

        // Extreme negative: target 255 loaded in the handshake cycle.
        step(1'b0, 8'd0, 1'b1, 8'd255, 1'b1);
        repeat (WIN) step(1'b1, 8'd0, 1'b0, 8'd0, 1'b0);
        wait_result("negative", -255, 1);

        // Truncation: samples 0..7 average 3.5 -> 3, target 3.
        step(1'b0, 8'd0, 1'b1, 8'd3, 1'b1);
        for (int i = 0; i < WIN; i++) step(1'b1, 8'(i), 1'b0, 8'd0, 1'b0);
        wait_result("truncation", 0, 1);

        // Backpressure: offers in HOLD are dropped and set overrun.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'd200, 1'b0, 8'd0, 1'b0);
            check("bp_err_valid", int'(bus.err_valid), 1);
            check("bp_err", int'(bus.err), 0);
            check("bp_sample_ready", int'(bus.sample_ready), 0);
            check("bp_overrun", int'(bus.overrun), 1);
        end
        step(1'b0, 8'd0, 1'b1, 8'd100, 1'b1);
        check("post_hs_err_valid", int'(bus.err_valid), 0);
        check("post_hs_sample_ready", int'(bus.sample_ready), 1);

        // Target change mid-window only affects the next window.
        repeat (4) step(1'b1, 8'd100, 1'b0, 8'd0, 1'b0);
        step(1'b1, 8'd100, 1'b1, 8'd50, 1'b0);
        repeat (WIN - 5) step(1'b1, 8'd100, 1'b0, 8'd0, 1'b0);
        wait_result("mid_load_same", 0, 1);
        step(1'b0, 8'd0, 1'b0, 8'd0, 1'b1);
        repeat (WIN) step(1'b1, 8'd100, 1'b0, 8'd0, 1'b0);
        wait_result("mid_load_next", 50, 1);
        check("overrun_sticky", int'(bus.overrun), 1);
        step(1'b0, 8'd0, 1'b0, 8'd0, 1'b1);

        // Reset mid-window discards the partial window.
        repeat (3) step(1'b1, 8'd250, 1'b0, 8'd0, 1'b0);
        reset_pulse("reset_mid");
        step(1'b1, 8'd10, 1'b1, 8'd7, 1'b0);
        repeat (WIN - 1) step(1'b1, 8'd10, 1'b0, 8'd0, 1'b0);
        wait_result("after_reset", 3, 1);
        step(1'b0, 8'd0, 1'b0, 8'd0, 1'b1);

        // Randomized traffic, all checked by the model and monitor.
        for (int i = 0; i < 600; i++) begin
            logic [7:0] s;
            logic [7:0] t;
            case ($urandom_range(3, 0))
                0:       s = 8'd0;
                1:       s = 8'd255;
                default: s = 8'($urandom);
            endcase
            t = ($urandom_range(3, 0) == 0) ? 8'd255 : 8'($urandom);
            step($urandom_range(3, 0) != 0, s, $urandom_range(7, 0) == 0, t,
                 $urandom_range(2, 0) != 0);
        end

        // Drain outstanding results.
        repeat (WIN + 4) step(1'b0, 8'd0, 1'b0, 8'd0, 1'b1);
        check("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

endmodule
